// File: rtl/kvadd_example_job_scheduler_if.sv
// Job scheduler bus bundle: descriptor input, datapath control, completion output.
// The master modport is the scheduler side; slave is the host/datapath side.
// Optional macro KVADD_SCHED_PERF_CNT_EN adds m_cmp_cycles.
interface kvadd_example_job_scheduler_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_ID_WIDTH         = 8
);
  logic                          s_job_valid;
  logic                          s_job_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0] s_job_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]  s_job_size;
  logic [C_ADDER_BIT_WIDTH-1:0]  s_job_constant;
  logic [C_ID_WIDTH-1:0]         s_job_id;

  logic                          dp_ap_start;
  logic                          dp_ap_done;
  logic [C_M_AXI_ADDR_WIDTH-1:0] dp_addr_offset;
  logic [C_XFER_SIZE_WIDTH-1:0]  dp_xfer_size_in_bytes;
  logic [C_ADDER_BIT_WIDTH-1:0]  dp_constant;

  logic                          m_cmp_valid;
  logic                          m_cmp_ready;
  logic [C_ID_WIDTH-1:0]         m_cmp_id;
  logic                          m_cmp_error;
`ifdef KVADD_SCHED_PERF_CNT_EN
  logic [31:0]                   m_cmp_cycles;
`endif

  logic                          busy;

  modport master (
    input  s_job_valid, s_job_addr, s_job_size, s_job_constant, s_job_id,
    input  dp_ap_done, m_cmp_ready,
    output s_job_ready,
    output dp_ap_start, dp_addr_offset, dp_xfer_size_in_bytes, dp_constant,
    output m_cmp_valid, m_cmp_id, m_cmp_error,
`ifdef KVADD_SCHED_PERF_CNT_EN
    output m_cmp_cycles,
`endif
    output busy
  );

  modport slave (
    output s_job_valid, s_job_addr, s_job_size, s_job_constant, s_job_id,
    output dp_ap_done, m_cmp_ready,
    input  s_job_ready,
    input  dp_ap_start, dp_addr_offset, dp_xfer_size_in_bytes, dp_constant,
    input  m_cmp_valid, m_cmp_id, m_cmp_error,
`ifdef KVADD_SCHED_PERF_CNT_EN
    input  m_cmp_cycles,
`endif
    input  busy
  );
endinterface

// File: rtl/kvadd_example_job_scheduler.sv
// Job scheduler for the vadd datapath: queues descriptors, splits each job into
// chunks of at most C_MAX_CHUNK_BYTES, runs one ap_start/ap_done per chunk and
// returns one completion record (id, error) per job.
// Optional macro KVADD_SCHED_PERF_CNT_EN adds a per-job cycle counter on m_cmp_cycles.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a descriptor; pops the FIFO head into work regs
// ST_LOAD   | validates size, computes next chunk, drives dp_* fields
// ST_START  | one-cycle dp_ap_start pulse
// ST_WAIT   | waiting for dp_ap_done; advances addr/remaining
// ST_REPORT | completion record held until m_cmp_ready
module kvadd_example_job_scheduler #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_ID_WIDTH         = 8,
  parameter int C_QUEUE_DEPTH      = 4,
  parameter int C_MAX_CHUNK_BYTES  = 65536
) (
  input  logic aclk,
  input  logic areset,
  kvadd_example_job_scheduler_if.master bus
);

  localparam int BUS_BYTES  = C_M_AXI_DATA_WIDTH / 8;
  localparam int ALIGN_BITS = $clog2(BUS_BYTES);
  localparam int PTR_W      = $clog2(C_QUEUE_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam logic [C_XFER_SIZE_WIDTH-1:0] MAX_CHUNK = C_XFER_SIZE_WIDTH'(C_MAX_CHUNK_BYTES);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(C_QUEUE_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_REPORT
  } state_t;

  state_t state, state_next;

  // descriptor FIFO
  logic [C_M_AXI_ADDR_WIDTH-1:0] q_addr  [C_QUEUE_DEPTH];
  logic [C_XFER_SIZE_WIDTH-1:0]  q_size  [C_QUEUE_DEPTH];
  logic [C_ADDER_BIT_WIDTH-1:0]  q_const [C_QUEUE_DEPTH];
  logic [C_ID_WIDTH-1:0]         q_id    [C_QUEUE_DEPTH];
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [CNT_W-1:0]              count, count_next;
  logic                          job_ready;
  logic                          push, pop, fifo_empty;

  // working registers for the job in flight
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_XFER_SIZE_WIDTH-1:0]  rem_q;
  logic [C_ADDER_BIT_WIDTH-1:0]  const_q;
  logic [C_ID_WIDTH-1:0]         id_q;
  logic                          err_q;
  logic [C_XFER_SIZE_WIDTH-1:0]  chunk_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] dp_addr_q;
  logic [C_ADDER_BIT_WIDTH-1:0]  dp_const_q;

  logic [C_XFER_SIZE_WIDTH-1:0]  chunk_sel;
  logic                          size_bad, last_chunk;
  logic                          load_chunk, load_err, chunk_done, cmp_accept;

  assign push       = bus.s_job_valid & job_ready;
  assign fifo_empty = (count == '0);

  // Pointer wrap is implicit: depth is a power of two and pointers are log2(depth) wide.
  // Occupancy bookkeeping; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // FIFO pointers, count and registered ready (ready reflects next-cycle fullness)
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      job_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_next;
      job_ready <= (count_next != DEPTH_CNT);
    end
  end

  // FIFO storage; contents are don't-care until written so no reset is needed
  always_ff @(posedge aclk) begin
    if (push) begin
      q_addr[wr_ptr]  <= bus.s_job_addr;
      q_size[wr_ptr]  <= bus.s_job_size;
      q_const[wr_ptr] <= bus.s_job_constant;
      q_id[wr_ptr]    <= bus.s_job_id;
    end
  end

  // rem_q holds the original size on the first LOAD; later LOADs only see
  // aligned non-zero remainders, so this check only ever fires for a new job.
  assign size_bad   = (rem_q == '0) || (rem_q[ALIGN_BITS-1:0] != '0);
  assign chunk_sel  = (rem_q > MAX_CHUNK) ? MAX_CHUNK : rem_q;
  assign last_chunk = (rem_q == chunk_q);

  // state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // next-state and control strobes
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_chunk = 1'b0;
    load_err   = 1'b0;
    chunk_done = 1'b0;
    cmp_accept = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (size_bad) begin
          load_err   = 1'b1;
          state_next = ST_REPORT;
        end else begin
          load_chunk = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: state_next = ST_WAIT;
      ST_WAIT: begin
        if (bus.dp_ap_done) begin
          chunk_done = 1'b1;
          state_next = last_chunk ? ST_REPORT : ST_LOAD;
        end
      end
      ST_REPORT: begin
        if (bus.m_cmp_ready) begin
          cmp_accept = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // working registers and the held datapath command fields
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q     <= '0;
      rem_q      <= '0;
      const_q    <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
      chunk_q    <= '0;
      dp_addr_q  <= '0;
      dp_const_q <= '0;
    end else begin
      if (pop) begin
        addr_q  <= q_addr[rd_ptr];
        rem_q   <= q_size[rd_ptr];
        const_q <= q_const[rd_ptr];
        id_q    <= q_id[rd_ptr];
        err_q   <= 1'b0;
      end
      if (load_err) err_q <= 1'b1;
      if (load_chunk) begin
        chunk_q    <= chunk_sel;
        dp_addr_q  <= addr_q;
        dp_const_q <= const_q;
      end
      if (chunk_done) begin
        addr_q <= addr_q + C_M_AXI_ADDR_WIDTH'(chunk_q);
        rem_q  <= rem_q - chunk_q;
      end
      if (cmp_accept) err_q <= 1'b0;
    end
  end

`ifdef KVADD_SCHED_PERF_CNT_EN
  logic [31:0] cycles_q;

  // cycles spent in LOAD/START/WAIT for the current job; a job rejected in LOAD reads 0
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cycles_q <= '0;
    end else if (pop) begin
      cycles_q <= '0;
    end else if ((state == ST_LOAD && !size_bad) || state == ST_START || state == ST_WAIT) begin
      if (cycles_q != 32'hFFFF_FFFF) cycles_q <= cycles_q + 32'd1;
    end
  end

  assign bus.m_cmp_cycles = cycles_q;
`endif

  assign bus.s_job_ready           = job_ready;
  assign bus.dp_ap_start           = (state == ST_START);
  assign bus.dp_addr_offset        = dp_addr_q;
  assign bus.dp_xfer_size_in_bytes = chunk_q;
  assign bus.dp_constant           = dp_const_q;
  assign bus.m_cmp_valid           = (state == ST_REPORT);
  assign bus.m_cmp_id              = id_q;
  assign bus.m_cmp_error           = err_q;
  assign bus.busy                  = !fifo_empty || (state != ST_IDLE);

endmodule
